regfile_port_arbiter: RTL and testbench
=======================================

Name: regfile_port_arbiter

Overview:
- Controller for the two-read/one-write register file stage.
- Shares the single write port (wd_addr/wd_data/w_enable) between two writeback requesters: req0 = ALU writeback, req1 = load writeback. Arbitration is round-robin.
- Gates the read port (r_enable) for the decode stage and stalls reads that hit an in-flight write.
- Sits between execute/memory writeback and REGISTER_STAGE2; drives that block's control and address inputs directly.

Parameters:
- DATA_W, 32, register data width
- ADDR_W, 5, register address width (32 registers, r0 hard-wired zero)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous active-high reset
- freeze  in  1  global hold: no grants, no reads while high
- wr0_vld  in  1  requester 0 write valid
- wr0_rdy  out  1  requester 0 accepted this cycle
- wr0_addr  in  ADDR_W  requester 0 destination register
- wr0_data  in  DATA_W  requester 0 write data
- wr1_vld  in  1  requester 1 write valid
- wr1_rdy  out  1  requester 1 accepted this cycle
- wr1_addr  in  ADDR_W  requester 1 destination register
- wr1_data  in  DATA_W  requester 1 write data
- rd_vld  in  1  decode requests a read of rs/rt
- rd_rs_addr  in  ADDR_W  source register rs
- rd_rt_addr  in  ADDR_W  source register rt
- rd_stall  out  1  read blocked by write hazard or freeze
- rs_addr  out  ADDR_W  to register file
- rt_addr  out  ADDR_W  to register file
- r_enable  out  1  to register file
- wd_addr  out  ADDR_W  to register file, registered
- wd_data  out  DATA_W  to register file, registered
- w_enable  out  1  to register file, registered

Behaviour:
- Reset (async, rst=1):
  - w_enable=0, wd_addr=0, wd_data=0.
  - Round-robin pointer last_gnt=1, so req0 wins the first conflict.
  - Combinational outputs follow their equations; with all inputs low, all are 0.
- Write handshake:
  - A transfer occurs when wrN_vld && wrN_rdy.
  - A requester must hold vld/addr/data stable until rdy.
  - rdy is combinational from the vld inputs, freeze and last_gnt.
- Grant rules:
  - freeze=1: both rdy=0.
  - Only one vld: that requester gets rdy=1.
  - Both vld: the requester != last_gnt gets rdy=1.
  - last_gnt updates to the granted index on every transfer; it is unchanged when there is no transfer.
- Output stage:
  - The accepted write appears on wd_addr/wd_data/w_enable exactly 1 cycle after acceptance.
  - No acceptance in a cycle → w_enable=0 next cycle; wd_addr/wd_data hold their previous values.
- r0 rule: a write with addr==0 is accepted (rdy=1, pointer updates) but the next-cycle w_enable stays 0.
- Back-to-back acceptance allowed every cycle (throughput 1 write/cycle). There is no internal buffering beyond the output register.
- Read path:
  - rs_addr/rt_addr = rd_rs_addr/rd_rt_addr, combinational.
  - Hazard hit on rs (and likewise on rt) when the address is nonzero and either:
    - w_enable && wd_addr == that address (write in flight this cycle), or
    - a non-r0 write to that address is accepted this cycle.
  - rd_stall = rd_vld && (freeze || hit).
  - r_enable = rd_vld && !rd_stall.
- Simultaneous read and write to the same register: the read stalls until the write has been committed (w_enable cycle passed), i.e. at least 2 cycles after acceptance.
- freeze asserted mid-stream: an already-registered write still completes (w_enable pulse is not cancelled). No new acceptances occur while freeze=1.
- rst asserted mid-operation: any pending registered write is dropped (w_enable forced 0 immediately) and the pointer returns to 1.

Decomposition:
- Shared package regfile_pkg: DATA_W/ADDR_W defaults, constant REG_ZERO=0, constant NUM_WR_REQ=2.
- One sub-module, rr_arb2: 2-way round-robin arbiter (vld[1:0], freeze → gnt[1:0], owns the last_gnt flop). Hazard compare and output register stay in the top.

Test Plan:
- Reset: rst=1 mid-run with w_enable=1 → w_enable, wd_addr, wd_data all 0 immediately; first conflict after release grants req0.
- Single write: wr0 vld, addr=11, data=3 at cycle N → wr0_rdy=1 at N; w_enable=1, wd_addr=11, wd_data=3 at N+1; w_enable=0 at N+2.
- Conflict fairness: both vld continuously (wr0 addr=7 data=5; wr1 addr=10 data=9) for 4 cycles → grants 0,1,0,1; wd_addr sequence 7,10,7,10.
- r0 discard: wr1 vld, addr=0, data=0xFFFF → wr1_rdy=1; w_enable stays 0; next conflict grants req0.
- Read hazard: write to addr 7 accepted at N, rd_vld with rs=7, rt=10 at N and N+1 → rd_stall=1 and r_enable=0 at N and N+1; at N+2 r_enable=1 and rd_stall=0.
- Freeze: freeze=1 with wr0 vld and rd_vld → wr0_rdy=0, rd_stall=1, r_enable=0; after freeze drops, write is accepted the same cycle.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared constants and types for the register-file write/read port controller.
// Defaults here match the 32 x 32-bit register file with r0 hard-wired to zero.
package regfile_pkg;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;
    localparam int REG_ZERO   = 0;
    localparam int NUM_WR_REQ = 2;

    typedef logic [NUM_WR_REQ-1:0] req_vec_t;
endpackage

// File: rtl/regfile_port_arbiter_rr_arb2.sv
// Two-way round-robin arbiter; owns the last-granted pointer.
// When both requesters are valid, the one that was not granted last wins.
module rr_arb2
    import regfile_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    input  logic     freeze,
    input  req_vec_t vld,
    output req_vec_t gnt
);
    logic last_gnt_reg;

    always_comb begin
        gnt = '0;
        if (!freeze) begin
            unique case (vld)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11:   gnt = last_gnt_reg ? 2'b01 : 2'b10;
                default: gnt = '0;
            endcase
        end
    end

    // Pointer starts at 1 so that requester 0 wins the first conflict.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_gnt_reg <= 1'b1;
        end else if (gnt[0]) begin
            last_gnt_reg <= 1'b0;
        end else if (gnt[1]) begin
            last_gnt_reg <= 1'b1;
        end
    end
endmodule

// File: rtl/regfile_port_arbiter.sv
// Shares the register-file write port between ALU and load writeback and gates
// decode reads that would race an accepted or in-flight write.
module regfile_port_arbiter
    import regfile_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              freeze,
    input  logic              wr0_vld,
    output logic              wr0_rdy,
    input  logic [ADDR_W-1:0] wr0_addr,
    input  logic [DATA_W-1:0] wr0_data,
    input  logic              wr1_vld,
    output logic              wr1_rdy,
    input  logic [ADDR_W-1:0] wr1_addr,
    input  logic [DATA_W-1:0] wr1_data,
    input  logic              rd_vld,
    input  logic [ADDR_W-1:0] rd_rs_addr,
    input  logic [ADDR_W-1:0] rd_rt_addr,
    output logic              rd_stall,
    output logic [ADDR_W-1:0] rs_addr,
    output logic [ADDR_W-1:0] rt_addr,
    output logic              r_enable,
    output logic [ADDR_W-1:0] wd_addr,
    output logic [DATA_W-1:0] wd_data,
    output logic              w_enable
);
    localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(REG_ZERO);

    req_vec_t          gnt;
    logic              acc_fire;
    logic              acc_real;
    logic [ADDR_W-1:0] acc_addr;
    logic [DATA_W-1:0] acc_data;
    logic [ADDR_W-1:0] src_addr [2];
    logic [1:0]        src_hit;

    rr_arb2 u_arb (
        .clk    (clk),
        .rst    (rst),
        .freeze (freeze),
        .vld    ({wr1_vld, wr0_vld}),
        .gnt    (gnt)
    );

    assign wr0_rdy  = gnt[0];
    assign wr1_rdy  = gnt[1];
    assign acc_fire = |gnt;
    assign acc_addr = gnt[1] ? wr1_addr : wr0_addr;
    assign acc_data = gnt[1] ? wr1_data : wr0_data;
    // Writes to r0 are accepted to keep the handshake moving but never committed.
    assign acc_real = acc_fire && (acc_addr != ZERO_ADDR);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_enable <= 1'b0;
            wd_addr  <= '0;
            wd_data  <= '0;
        end else begin
            w_enable <= acc_real;
            if (acc_real) begin
                wd_addr <= acc_addr;
                wd_data <= acc_data;
            end
        end
    end

    assign rs_addr     = rd_rs_addr;
    assign rt_addr     = rd_rt_addr;
    assign src_addr[0] = rd_rs_addr;
    assign src_addr[1] = rd_rt_addr;

    // A source hits if it matches the write being accepted now or the one
    // being committed now; the register file value is stale in both cases.
    for (genvar gi = 0; gi < 2; gi++) begin : g_hazard
        assign src_hit[gi] = (src_addr[gi] != ZERO_ADDR) &&
                             ((w_enable && (wd_addr == src_addr[gi])) ||
                              (acc_real && (acc_addr == src_addr[gi])));
    end

    assign rd_stall = rd_vld && (freeze || (|src_hit));
    assign r_enable = rd_vld && !rd_stall;
endmodule

// File: tb/tb_regfile_port_arbiter.sv
// Randomised and directed bench for regfile_port_arbiter against a rule-level model.
module tb_regfile_port_arbiter;
    localparam int DW = 32;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          freeze = 1'b0;
    logic          wr0_vld = 1'b0, wr1_vld = 1'b0;
    logic          wr0_rdy, wr1_rdy;
    logic [AW-1:0] wr0_addr = '0, wr1_addr = '0;
    logic [DW-1:0] wr0_data = '0, wr1_data = '0;
    logic          rd_vld = 1'b0;
    logic [AW-1:0] rd_rs_addr = '0, rd_rt_addr = '0;
    logic          rd_stall, r_enable, w_enable;
    logic [AW-1:0] rs_addr, rt_addr, wd_addr;
    logic [DW-1:0] wd_data;

    regfile_port_arbiter #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk(clk), .rst(rst), .freeze(freeze),
        .wr0_vld(wr0_vld), .wr0_rdy(wr0_rdy), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
        .wr1_vld(wr1_vld), .wr1_rdy(wr1_rdy), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
        .rd_vld(rd_vld), .rd_rs_addr(rd_rs_addr), .rd_rt_addr(rd_rt_addr),
        .rd_stall(rd_stall), .rs_addr(rs_addr), .rt_addr(rt_addr), .r_enable(r_enable),
        .wd_addr(wd_addr), .wd_data(wd_data), .w_enable(w_enable)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Requester sources: a pending write is held stable until granted.
    bit      p_vld [2];
    int      p_addr[2];
    int      p_data[2];

    // Model state: who was granted last, and the write committed next cycle.
    int      m_last = 1;
    bit      m_we = 0;
    int      m_waddr = 0;
    longint  m_wdata = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic bit busy(input int a, input bit acc, input int acc_a);
        if (a == 0) return 0;
        return (m_we && m_waddr == a) || (acc && acc_a != 0 && acc_a == a);
    endfunction

    task automatic apply();
        wr0_vld  = p_vld[0];
        wr0_addr = AW'(p_addr[0]);
        wr0_data = DW'(p_data[0]);
        wr1_vld  = p_vld[1];
        wr1_addr = AW'(p_addr[1]);
        wr1_data = DW'(p_data[1]);
    endtask

    // One clock: inputs already set, check at negedge, update model, step past posedge.
    task automatic cycle();
        int win;
        bit g0, g1, acc, stall;
        int acc_a;
        int acc_d;
        apply();
        @(negedge clk);
        g0 = 0; g1 = 0;
        if (!freeze) begin
            if (p_vld[0] && p_vld[1]) begin
                win = (m_last == 0) ? 1 : 0;
                g0 = (win == 0); g1 = (win == 1);
            end else begin
                g0 = p_vld[0]; g1 = p_vld[1];
            end
        end
        acc   = g0 || g1;
        acc_a = g1 ? p_addr[1] : p_addr[0];
        acc_d = g1 ? p_data[1] : p_data[0];
        stall = rd_vld && (freeze || busy(int'(rd_rs_addr), acc, acc_a) ||
                           busy(int'(rd_rt_addr), acc, acc_a));
        chk("wr0_rdy", 64'(wr0_rdy), 64'(g0));
        chk("wr1_rdy", 64'(wr1_rdy), 64'(g1));
        chk("rd_stall", 64'(rd_stall), 64'(stall));
        chk("r_enable", 64'(r_enable), 64'(rd_vld && !stall));
        chk("rs_addr", 64'(rs_addr), 64'(rd_rs_addr));
        chk("rt_addr", 64'(rt_addr), 64'(rd_rt_addr));
        chk("w_enable", 64'(w_enable), 64'(m_we));
        if (m_we) begin
            chk("wd_addr", 64'(wd_addr), 64'(m_waddr));
            chk("wd_data", 64'(wd_data), 64'(m_wdata));
        end
        if (acc) m_last = g1 ? 1 : 0;
        m_we = acc && (acc_a != 0);
        if (m_we) begin
            m_waddr = acc_a;
            m_wdata = longint'(unsigned'(acc_d));
        end
        if (g0) p_vld[0] = 0;
        if (g1) p_vld[1] = 0;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("rst_w_enable", 64'(w_enable), 64'd0);
        chk("rst_wd_addr", 64'(wd_addr), 64'd0);
        chk("rst_wd_data", 64'(wd_data), 64'd0);
        m_last = 1; m_we = 0; m_waddr = 0; m_wdata = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic set_req(input int idx, input int a, input int d);
        p_vld[idx] = 1; p_addr[idx] = a; p_data[idx] = d;
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            p_vld[i] = 0; p_addr[i] = 0; p_data[i] = 0;
        end
        @(posedge clk);
        #1;
        do_reset();
        cycle();                                   // idle after reset: all zero

        set_req(0, 11, 3);                         // single write
        repeat (3) cycle();

        do_reset();
        for (int i = 0; i < 5; i++) begin          // conflict fairness 0,1,0,1
            if (i < 4) begin
                set_req(0, 7, 5);
                set_req(1, 10, 9);
            end
            cycle();
        end

        set_req(1, 0, 'hFFFF);                     // r0 discard
        cycle();
        set_req(0, 7, 5);
        set_req(1, 10, 9);
        repeat (2) cycle();
        p_vld[0] = 0; p_vld[1] = 0;
        cycle();

        set_req(0, 7, 'h77);                       // read hazard on rs
        rd_vld = 1; rd_rs_addr = 7; rd_rt_addr = 10;
        repeat (3) cycle();
        rd_vld = 0;

        freeze = 1; set_req(0, 4, 'h44); rd_vld = 1; rd_rs_addr = 1; rd_rt_addr = 2;
        repeat (2) cycle();
        freeze = 0;
        repeat (2) cycle();
        rd_vld = 0;

        set_req(0, 5, 'h55);                       // reset with write in flight
        cycle();
        do_reset();
        set_req(0, 7, 5);
        set_req(1, 10, 9);
        repeat (3) cycle();

        for (int c = 0; c < 3000; c++) begin
            for (int r = 0; r < 2; r++) begin
                if (!p_vld[r] && ($urandom_range(0, 2) != 0))
                    set_req(r, int'($urandom_range(0, 7)), int'($urandom));
            end
            freeze     = ($urandom_range(0, 7) == 0);
            rd_vld     = ($urandom_range(0, 1) == 1);
            rd_rs_addr = AW'($urandom_range(0, 7));
            rd_rt_addr = AW'($urandom_range(0, 7));
            cycle();
            if (c == 1500) do_reset();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
